// File: rtl/btn_event_sched.sv
// rtl/btn_event_sched.sv - shared button debounce, press/long/release detection and round-robin event FIFO
// Auto-repeat events (type 11) exist only when BTN_REPEAT_EN is defined.
module btn_event_sched #(
  parameter int ID_W         = 2,
  parameter int TICK_DIV     = 17,
  parameter int LONG_TICKS   = 250,
  parameter int REPEAT_TICKS = 50,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic                 clk,
  input  logic                 reset_p,
  input  logic [2**ID_W-1:0]   btn,
  output logic                 evt_valid,
  input  logic                 evt_ready,
  output logic [ID_W-1:0]      evt_id,
  output logic [1:0]           evt_type,
  output logic [2**ID_W-1:0]   btn_level,
  output logic                 overflow
);
  localparam int N_BTN = 2**ID_W;
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam logic [7:0] LONG_M1 = 8'(LONG_TICKS - 1);
`ifdef BTN_REPEAT_EN
  localparam logic REP_EN = 1'b1;
`else
  localparam logic REP_EN = 1'b0;
`endif
  // Type bit order: 0 press, 1 long, 2 release, 3 repeat
  localparam logic [3:0] TYPE_MASK = {REP_EN && (REPEAT_TICKS > 0), 3'b111};

  logic [N_BTN-1:0]    sync1, sync2, held, rise, long_hit, rep_hit;
  logic [TICK_DIV-1:0] div;
  logic                tick;
  logic [7:0]          hold [N_BTN];
  logic [3:0]          pend [N_BTN];
  logic [3:0]          set_v [N_BTN];
  logic [3:0]          clr_v [N_BTN];
  logic                ovf_hit;
  logic [ID_W-1:0]     rr, idx, gnt_id;
  logic [1:0]          gnt_type;
  logic                gnt_valid, wr_en, full, empty;
  logic [ID_W+1:0]     mem [FIFO_DEPTH];
  logic [PTR_W:0]      wr_ptr, rd_ptr;

  assign tick = &div;
  assign held = sync2 & btn_level;
  assign rise = sync2 & ~btn_level;

  always_ff @(posedge clk or posedge reset_p) begin
    if (reset_p) begin
      sync1     <= '0;
      sync2     <= '0;
      div       <= '0;
      btn_level <= '0;
    end else begin
      sync1 <= btn;
      sync2 <= sync1;
      div   <= div + TICK_DIV'(1);
      if (tick) btn_level <= sync2;
    end
  end

  always_ff @(posedge clk or posedge reset_p) begin
    if (reset_p) begin
      for (int b = 0; b < N_BTN; b++) hold[b] <= '0;
    end else if (tick) begin
      for (int b = 0; b < N_BTN; b++)
        if (held[b]) hold[b] <= (hold[b] == 8'hFF) ? 8'hFF : hold[b] + 8'd1;
        else         hold[b] <= '0;
    end
  end

  always_comb begin
    long_hit = '0;
    for (int b = 0; b < N_BTN; b++)
      long_hit[b] = tick & held[b] & (hold[b] == LONG_M1);
  end

`ifdef BTN_REPEAT_EN
  localparam logic [7:0] REP_M1 = 8'(REPEAT_TICKS - 1);
  logic [7:0] rep [N_BTN];

  always_comb begin
    rep_hit = '0;
    for (int b = 0; b < N_BTN; b++)
      rep_hit[b] = tick & held[b] & (hold[b] > LONG_M1) & (rep[b] == REP_M1);
  end

  always_ff @(posedge clk or posedge reset_p) begin
    if (reset_p) begin
      for (int b = 0; b < N_BTN; b++) rep[b] <= '0;
    end else if (tick) begin
      for (int b = 0; b < N_BTN; b++)
        if (!held[b] || long_hit[b] || rep_hit[b]) rep[b] <= '0;
        else if (hold[b] > LONG_M1)                rep[b] <= rep[b] + 8'd1;
    end
  end
`else
  assign rep_hit = '0;
`endif

  // Round-robin search from rr; lowest type code of the chosen button wins
  always_comb begin
    gnt_valid = 1'b0;
    gnt_id    = '0;
    gnt_type  = '0;
    idx       = '0;
    for (int i = 0; i < N_BTN; i++) begin
      idx = rr + ID_W'(i);
      if (!gnt_valid && (|pend[idx])) begin
        gnt_valid = 1'b1;
        gnt_id    = idx;
        if      (pend[idx][0]) gnt_type = 2'd0;
        else if (pend[idx][1]) gnt_type = 2'd1;
        else if (pend[idx][2]) gnt_type = 2'd2;
        else                   gnt_type = 2'd3;
      end
    end
  end

  assign wr_en = gnt_valid & ~full;

  // A set landing on a bit the arbiter clears this cycle is a fresh event, not an overflow
  always_comb begin
    ovf_hit = 1'b0;
    for (int b = 0; b < N_BTN; b++) begin
      set_v[b] = {rep_hit[b], tick & ~sync2[b] & btn_level[b], long_hit[b], tick & rise[b]} & TYPE_MASK;
      clr_v[b] = '0;
      if (wr_en && (gnt_id == ID_W'(b))) clr_v[b][gnt_type] = 1'b1;
      if (|(set_v[b] & pend[b] & ~clr_v[b])) ovf_hit = 1'b1;
    end
  end

  assign empty     = (wr_ptr == rd_ptr);
  assign full      = (wr_ptr[PTR_W] != rd_ptr[PTR_W]) && (wr_ptr[PTR_W-1:0] == rd_ptr[PTR_W-1:0]);
  assign evt_valid = ~empty;
  assign {evt_id, evt_type} = mem[rd_ptr[PTR_W-1:0]];

  always_ff @(posedge clk or posedge reset_p) begin
    if (reset_p) begin
      for (int b = 0; b < N_BTN; b++) pend[b] <= '0;
      for (int e = 0; e < FIFO_DEPTH; e++) mem[e] <= '0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      rr       <= '0;
      overflow <= 1'b0;
    end else begin
      for (int b = 0; b < N_BTN; b++) pend[b] <= (pend[b] & ~clr_v[b]) | set_v[b];
      if (ovf_hit) overflow <= 1'b1;
      if (wr_en) begin
        mem[wr_ptr[PTR_W-1:0]] <= {gnt_id, gnt_type};
        wr_ptr                 <= wr_ptr + (PTR_W+1)'(1);
        rr                     <= gnt_id + ID_W'(1);
      end
      if (evt_valid && evt_ready) rd_ptr <= rd_ptr + (PTR_W+1)'(1);
    end
  end
endmodule
